// File: rtl/ddr2_rank_dispatcher.sv
// ddr2_rank_dispatcher
//
// Steers host commands to NUM_RANKS per-rank DDR2 controller cores and
// merges read data back to the host strictly in issue order.
//
// Ports:
//   CLK, RESET_N                  clock, asynchronous active-low reset
//   CMD, SZ, ADDR, cmd_put        host command channel; ADDR MSBs pick the rank
//   DIN, put_dataFIFO             host write data, strobe steered by ADDR rank
//   FETCHING                      host can take read data this cycle
//   NOTFULL                       a cmd_put this cycle will be accepted
//   READY                         all cores ready
//   DOUT, RADDR, VALIDOUT         merged read return, rank restored in RADDR
//   OUTSTANDING                   reads accepted but not fully returned
//   ERR_OVF                       sticky: a command was dropped
//   R_*                           flattened per-rank core interface, rank 0 in LSBs
module ddr2_rank_dispatcher #(
  parameter int          HOST_ADDR_WIDTH = 26,
  parameter int          ADDR_WIDTH      = 25,
  parameter int          RANK_BITS       = 1,
  parameter int          DATA_WIDTH      = 64,
  parameter int          QDEPTH          = 4,
  parameter int          TAG_DEPTH       = 16,
  parameter logic [2:0]  CMD_READ        = 3'b001,
  localparam int         NUM_RANKS       = 2 ** RANK_BITS,
  localparam int         OCW             = $clog2(TAG_DEPTH) + 1
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic [2:0]                       CMD,
  input  logic [1:0]                       SZ,
  input  logic [HOST_ADDR_WIDTH-1:0]       ADDR,
  input  logic                             cmd_put,
  input  logic [DATA_WIDTH-1:0]            DIN,
  input  logic                             put_dataFIFO,
  input  logic                             FETCHING,
  output logic                             NOTFULL,
  output logic                             READY,
  output logic [DATA_WIDTH-1:0]            DOUT,
  output logic [HOST_ADDR_WIDTH-1:0]       RADDR,
  output logic                             VALIDOUT,
  output logic [OCW-1:0]                   OUTSTANDING,
  output logic                             ERR_OVF,
  output logic [NUM_RANKS*3-1:0]           R_CMD,
  output logic [NUM_RANKS*2-1:0]           R_SZ,
  output logic [NUM_RANKS*ADDR_WIDTH-1:0]  R_ADDR,
  output logic [NUM_RANKS-1:0]             R_cmd_put,
  input  logic [NUM_RANKS-1:0]             R_READY,
  output logic [NUM_RANKS*DATA_WIDTH-1:0]  R_DIN,
  output logic [NUM_RANKS-1:0]             R_put_dataFIFO,
  output logic [NUM_RANKS-1:0]             R_FETCHING,
  input  logic [NUM_RANKS*DATA_WIDTH-1:0]  R_DOUT,
  input  logic [NUM_RANKS*ADDR_WIDTH-1:0]  R_RADDR,
  input  logic [NUM_RANKS-1:0]             R_VALIDOUT
);

  localparam int QPW = $clog2(QDEPTH);
  localparam int QCW = QPW + 1;
  localparam int TPW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLD} disp_state_t;

  typedef struct packed {
    logic [2:0]            cmd;
    logic [1:0]            sz;
    logic [ADDR_WIDTH-1:0] addr;
  } cmd_entry_t;

  typedef struct packed {
    logic [RANK_BITS-1:0] rank;
    logic [1:0]           sz;
  } tag_entry_t;

  // ---------------- host command decode / admission ----------------
  logic [RANK_BITS-1:0] in_rank;
  logic [QCW-1:0]       q_count [NUM_RANKS];
  logic [OCW-1:0]       tag_count;
  logic                 is_read, accept, tag_push;
  cmd_entry_t           new_entry;

  assign in_rank   = ADDR[HOST_ADDR_WIDTH-1 -: RANK_BITS];
  assign is_read   = (CMD == CMD_READ);
  // Admission uses registered counts only, so a pop in this cycle never helps.
  assign NOTFULL   = (q_count[in_rank] < QCW'(QDEPTH)) &&
                     (!is_read || (tag_count < OCW'(TAG_DEPTH)));
  assign accept    = cmd_put && NOTFULL;
  assign tag_push  = accept && is_read;
  assign new_entry = '{cmd: CMD, sz: SZ, addr: ADDR[ADDR_WIDTH-1:0]};

  assign READY = &R_READY;
  assign R_DIN = {NUM_RANKS{DIN}};

  // NOTE: sequential state is updated with non-blocking (<=) assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                ERR_OVF <= 1'b0;
    else if (cmd_put && !NOTFULL) ERR_OVF <= 1'b1;
  end

  // ---------------- per-rank queue and dispatch FSM ----------------
  for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
    cmd_entry_t     mem [QDEPTH];
    cmd_entry_t     head;
    logic [QPW-1:0] wr_ptr, rd_ptr;
    logic [QCW-1:0] count;
    logic           push, pop;
    disp_state_t    state, state_next;

    assign push = accept && (in_rank == RANK_BITS'(r));
    assign pop  = (state == ST_ISSUE);
    assign head = mem[rd_ptr];

    // NOTE: the queue storage has no reset; validity is tracked solely by the
    // pointers and count, which are reset.
    always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        state  <= ST_IDLE;
      end else begin
        state <= state_next;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // NOTE: next-state defaults to the current state before the case so no
    // path leaves it unassigned (no latch).
    always_comb begin
      state_next = state;
      case (state)
        ST_IDLE:  if ((count != '0) && R_READY[r]) state_next = ST_ISSUE;
        ST_ISSUE: state_next = ST_HOLD;   // head popped this cycle
        ST_HOLD:  state_next = ST_IDLE;   // covers the core's READY lag
        default:  state_next = ST_IDLE;
      endcase
    end

    assign q_count[r]                         = count;
    assign R_cmd_put[r]                       = (state == ST_ISSUE);
    assign R_CMD[r*3 +: 3]                    = head.cmd;
    assign R_SZ[r*2 +: 2]                     = head.sz;
    assign R_ADDR[r*ADDR_WIDTH +: ADDR_WIDTH] = head.addr;
    assign R_put_dataFIFO[r]                  = put_dataFIFO && (in_rank == RANK_BITS'(r));
  end

  // ---------------- in-order read merge ----------------
  tag_entry_t           tag_mem [TAG_DEPTH];
  tag_entry_t           head_tag;
  logic [TPW-1:0]       tag_wr, tag_rd;
  logic [5:0]           beat_cnt;
  logic [2:0]           sz_plus1;
  logic                 tv, loaded, last_beat;
  logic [RANK_BITS-1:0] head;

  assign head_tag    = tag_mem[tag_rd];
  assign head        = head_tag.rank;
  assign tv          = (tag_count != '0);
  // A zero count means the head's burst length is not loaded yet: this is the
  // single bubble cycle at every head change.
  assign loaded      = (beat_cnt != '0);
  assign VALIDOUT    = tv && loaded && R_VALIDOUT[head] && FETCHING;
  assign last_beat   = VALIDOUT && (beat_cnt == 6'd1);
  assign sz_plus1    = {1'b0, head_tag.sz} + 3'd1;
  assign OUTSTANDING = tag_count;

  always_comb begin
    R_FETCHING = '0;
    DOUT       = '0;
    RADDR      = '0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (head == RANK_BITS'(r)) begin
        R_FETCHING[r] = FETCHING && tv && loaded;
        DOUT          = R_DOUT[r*DATA_WIDTH +: DATA_WIDTH];
        RADDR         = {head, R_RADDR[r*ADDR_WIDTH +: ADDR_WIDTH]};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (tag_push) tag_mem[tag_wr] <= '{rank: in_rank, sz: SZ};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tag_wr    <= '0;
      tag_rd    <= '0;
      tag_count <= '0;
      beat_cnt  <= '0;
    end else begin
      if (tag_push)  tag_wr <= tag_wr + 1'b1;
      if (last_beat) tag_rd <= tag_rd + 1'b1;
      case ({tag_push, last_beat})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
      if (tv && !loaded) beat_cnt <= {sz_plus1, 3'b000};
      else if (VALIDOUT) beat_cnt <= beat_cnt - 1'b1;
    end
  end

endmodule

// File: doc/ddr2_rank_dispatcher.md
# ddr2_rank_dispatcher

Multi-rank command dispatcher and in-order read merger between the 64-bit server host interface and NUM_RANKS per-rank DDR2 controller cores. It decodes the upper RANK_BITS of the host address into a rank index and queues each command in that rank's FIFO. Ranks drain their queues independently. Read data returning from the ranks is merged back to the host strictly in host issue order, with the rank index restored in the upper bits of RADDR.

## Interface
- HOST_ADDR_WIDTH, 26, host word address width; equals ADDR_WIDTH+RANK_BITS
- ADDR_WIDTH, 25, per-rank core address width
- RANK_BITS, 1, rank index bits (≥1); NUM_RANKS = 2**RANK_BITS
- DATA_WIDTH, 64, host and per-rank data width
- QDEPTH, 4, per-rank command FIFO depth (power of 2, ≥2)
- TAG_DEPTH, 16, outstanding-read order queue depth (power of 2)
- CMD_READ, 3'b001, CMD encoding treated as a read

Ports:
- CLK  in  1  clock; all logic rising-edge
- RESET_N  in  1  reset, asynchronous assert, active-low
- CMD  in  3  host command
- SZ  in  2  burst size; a read returns (SZ+1)*8 beats
- ADDR  in  HOST_ADDR_WIDTH  host address; [MSB -: RANK_BITS] selects the rank
- cmd_put  in  1  enqueue strobe
- DIN  in  DATA_WIDTH  host write data
- put_dataFIFO  in  1  write-data strobe, steered by the rank bits of ADDR in the same cycle
- FETCHING  in  1  host able to accept read data
- NOTFULL  out  1  a cmd_put this cycle will be accepted
- READY  out  1  AND of R_READY
- DOUT  out  DATA_WIDTH  merged read data
- RADDR  out  HOST_ADDR_WIDTH  {head rank, R_RADDR of head rank}
- VALIDOUT  out  1  DOUT/RADDR valid
- OUTSTANDING  out  $clog2(TAG_DEPTH)+1  reads accepted but not fully returned
- ERR_OVF  out  1  sticky: a cmd_put was dropped
- R_CMD / R_SZ / R_ADDR  out  NUM_RANKS×3 / ×2 / ×ADDR_WIDTH  per-rank command fields, flattened, rank 0 in the LSBs
- R_cmd_put  out  NUM_RANKS  per-rank enqueue pulse
- R_READY  in  NUM_RANKS  core READY
- R_DIN  out  NUM_RANKS×DATA_WIDTH  write data, DIN replicated to every rank
- R_put_dataFIFO  out  NUM_RANKS  steered data strobe
- R_FETCHING  out  NUM_RANKS  per-rank fetch enable
- R_DOUT / R_RADDR  in  NUM_RANKS×DATA_WIDTH / ×ADDR_WIDTH  core read return
- R_VALIDOUT  in  NUM_RANKS  core VALIDOUT

## Operation
- Let rank = ADDR[HOST_ADDR_WIDTH-1 -: RANK_BITS].
- NOTFULL is combinational. It is 1 when both hold:
  - that rank's queue count is below QDEPTH;
  - CMD≠CMD_READ, or the tag count is below TAG_DEPTH.
  - A pop in the same cycle does not raise NOTFULL.
- On cmd_put with NOTFULL=1:
  - Push {CMD, SZ, ADDR[ADDR_WIDTH-1:0]} into queue[rank].
  - If the command is a read, also push {rank, SZ} into the tag queue.
- On cmd_put with NOTFULL=0: drop the command, leave all queues unchanged, and set ERR_OVF (cleared only by reset).
- Per-rank dispatch runs independently in each rank. States are IDLE, ISSUE and HOLD:
  - IDLE→ISSUE when the queue is non-empty and R_READY[r]=1.
  - ISSUE lasts one cycle. R_cmd_put[r]=1 with R_CMD/R_SZ/R_ADDR driven from the queue head; the head is popped; next state is HOLD.
  - HOLD lasts one cycle, covering the core's READY lag; next state is IDLE.
  - Minimum spacing is therefore one issue every 3 cycles per rank.
- Write data: R_put_dataFIFO[r] = put_dataFIFO & (rank==r). R_DIN[r] = DIN for every r.
- Read merge:
  - head = rank field of the tag-queue head. tv = tag queue non-empty.
  - R_FETCHING[r] = FETCHING & tv & (r==head).
  - VALIDOUT = tv & R_VALIDOUT[head] & FETCHING.
  - DOUT = R_DOUT[head]. RADDR = {head, R_RADDR[head]}.
  - The beat counter loads (SZ+1)*8 when a tag becomes head. It decrements on each VALIDOUT. On the last beat the tag pops and the next tag's count loads in the following cycle.
  - R_VALIDOUT from a non-head rank is ignored; that data stays held in its core.
- Tag push and pop in the same cycle are allowed; OUTSTANDING is unchanged.

## Timing
- Reset (RESET_N=0, asynchronous):
  - all queues empty, dispatch FSMs in IDLE, beat counter 0;
  - R_cmd_put=0, ERR_OVF=0, OUTSTANDING=0, VALIDOUT=0, R_FETCHING=0;
  - NOTFULL=1.
- Reset asserted mid-burst discards all queued and outstanding state immediately.
- Command accepted at edge t gives R_cmd_put high in cycle t+1 at the earliest, when R_READY is high.
- Read-return path from R_VALIDOUT to VALIDOUT is combinational, zero latency.
- Bursts are contiguous: no idle cycle is inserted between bursts from the same or different ranks once the next tag's count is loaded. There is one bubble cycle at a head change.
- OUTSTANDING increments on a read push and decrements on the last beat.

## Test plan
- Reset defaults: RESET_N low mid-traffic → all outputs at reset values in the same cycle; NOTFULL=1 and OUTSTANDING=0 after release.
- Rank steering (RANK_BITS=1): read at ADDR=0x2000010 → R_cmd_put[1] pulses with R_ADDR[1]=0x0000010; R_cmd_put[0] stays 0.
- In-order merge: read SZ=0 to rank 1, then read SZ=0 to rank 0; rank 0 returns data first → VALIDOUT stays 0 until rank 1 data arrives; host sees 8 beats with RADDR[25]=1, then 8 beats with RADDR[25]=0.
- Queue full: 5 writes to rank 0 with QDEPTH=4 and R_READY[0]=0 → NOTFULL=0 on the 5th, command dropped, ERR_OVF=1, and exactly 4 R_cmd_put pulses once R_READY rises.
- Tag full: 16 reads with no returns → NOTFULL=0 for the 17th read while a write to the same rank is still accepted; OUTSTANDING=16.
- Backpressure: FETCHING low mid-burst → R_FETCHING=0 and VALIDOUT=0; beat count resumes with no loss.
